// File: rtl/apb_slave_regfile_if.sv
// APB completer-side bus bundle: selects, strobes, address/data and the response.
interface apb_slave_regfile_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 3;

  logic [SEL_W-1:0]  Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic [DATA_W-1:0] Prdata;
  logic              Pready;
  logic              Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file, programmable wait states
// and error response for misaligned / out-of-range accesses.
module apb_slave_regfile #(
  parameter int unsigned SLAVE_ID    = 0,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                 Hclk,
  input  logic                 Hreset,
  apb_slave_regfile_if.slave   apb,
  output logic                 xfer_done
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  SEL_BIT = 2'(SLAVE_ID);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                xfer_done_q, xfer_done_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic                sel_c;
  logic                addr_err_c;
  logic [IDX_W-1:0]    addr_idx_c;

  // Address decode for the setup cycle; only our own select bit matters.
  always_comb begin
    sel_c      = apb.Pselx[SEL_BIT];
    addr_err_c = (|apb.Paddr[1:0])
               | (32'(apb.Paddr[11:2]) >= NUM_REGS)
               | (|apb.Paddr[31:12]);
    addr_idx_c = IDX_W'(apb.Paddr[11:2]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    prdata_d    = prdata_q;
    xfer_done_d = 1'b0;
    regs_d      = regs_q;

    case (state_q)
      S_IDLE: begin
        if (sel_c && !apb.Penable) begin
          write_d = apb.Pwrite;
          err_d   = addr_err_c;
          idx_d   = addr_idx_c;
          wdata_d = apb.Pwdata;
          if (WAIT_CYCLES == 0) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = addr_err_c;
            prdata_d  = (!apb.Pwrite && !addr_err_c) ? regs_q[addr_idx_c] : '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end

      S_WAIT: begin
        if (!sel_c) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (apb.Penable) begin
          if (cnt_q <= CNT_W'(1)) begin
            // Last wait cycle: present the response in the next access cycle.
            state_d   = S_RESP;
            cnt_d     = '0;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (!write_q && !err_q) ? regs_q[idx_q] : '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_RESP: begin
        if (!sel_c) begin
          state_d   = S_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (apb.Penable) begin
          if (write_q && !err_q) begin
            regs_d[idx_q] = wdata_q;
          end
          state_d     = S_IDLE;
          pready_d    = 1'b0;
          pslverr_d   = 1'b0;
          prdata_d    = '0;
          xfer_done_d = 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      xfer_done_q <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      xfer_done_q <= xfer_done_d;
      regs_q      <= regs_d;
    end
  end

  assign apb.Pready   = pready_q;
  assign apb.Pslverr  = pslverr_q;
  assign apb.Prdata   = prdata_q;
  assign xfer_done    = xfer_done_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: a zero-wait instance and a two-wait instance.
module tb_apb_slave_regfile;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
  } exp_t;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  sel0, sel2;
  logic        pen, pwr;
  logic [31:0] paddr, pwdata;
  logic        done0, done2;

  int n_err    = 0;
  int n_checks = 0;

  exp_t        sb_q[$];
  logic [31:0] m0 [8];
  logic [31:0] m2 [8];

  always #5 Hclk = ~Hclk;

  apb_slave_regfile_if bus0 ();
  apb_slave_regfile_if bus2 ();

  assign bus0.Pselx   = sel0;
  assign bus0.Penable = pen;
  assign bus0.Pwrite  = pwr;
  assign bus0.Paddr   = paddr;
  assign bus0.Pwdata  = pwdata;
  assign bus2.Pselx   = sel2;
  assign bus2.Penable = pen;
  assign bus2.Pwrite  = pwr;
  assign bus2.Paddr   = paddr;
  assign bus2.Pwdata  = pwdata;

  apb_slave_regfile #(.SLAVE_ID(0), .NUM_REGS(8), .WAIT_CYCLES(0)) u_dut0 (
    .Hclk(Hclk), .Hreset(Hreset), .apb(bus0.slave), .xfer_done(done0)
  );

  apb_slave_regfile #(.SLAVE_ID(2), .NUM_REGS(8), .WAIT_CYCLES(2)) u_dut2 (
    .Hclk(Hclk), .Hreset(Hreset), .apb(bus2.slave), .xfer_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample(input int d, output logic rdy, output logic slv,
                        output logic dn, output logic [31:0] rd);
    if (d == 0) begin
      rdy = bus0.Pready; slv = bus0.Pslverr; dn = done0; rd = bus0.Prdata;
    end else begin
      rdy = bus2.Pready; slv = bus2.Pslverr; dn = done2; rd = bus2.Prdata;
    end
  endtask

  function automatic logic addr_err(input logic [31:0] a);
    return (|a[1:0]) || (a[11:2] >= 10'd8) || (|a[31:12]);
  endfunction

  function automatic logic [31:0] model_rd(input int d, input int idx);
    return (d == 0) ? m0[idx] : m2[idx];
  endfunction

  task automatic bus_idle();
    sel0 = 3'b000; sel2 = 3'b000; pen = 1'b0;
    @(negedge Hclk);
  endtask

  // One complete transfer starting at the current negedge; ends at the negedge
  // following completion so another transfer can follow back-to-back.
  task automatic xfer(input int d, input logic [2:0] sel, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data);
    exp_t        e;
    logic        err, rdy, slv, dn, seen;
    logic [31:0] rd;
    int          waits, idx, exp_waits;
    err       = addr_err(addr);
    idx       = int'(addr[4:2]);
    exp_waits = (d == 0) ? 0 : 2;
    e.slverr  = err;
    e.rdata   = (!wr && !err) ? model_rd(d, idx) : 32'h0;
    sb_q.push_back(e);

    if (d == 0) begin sel0 = sel; sel2 = 3'b000; end
    else        begin sel2 = sel; sel0 = 3'b000; end
    pen = 1'b0; pwr = wr; paddr = addr; pwdata = data;
    @(negedge Hclk);
    pen   = 1'b1;
    waits = 0;
    seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      sample(d, rdy, slv, dn, rd);
      if (rdy) begin
        seen = 1'b1;
        break;
      end
      waits++;
      // Wiggle the bus during waits; the latched values must win.
      paddr  = paddr ^ 32'h0000_0004;
      pwdata = ~pwdata;
      pwr    = ~pwr;
      @(negedge Hclk);
    end
    if (!seen) begin
      chk("pready_timeout", 32'(seen), 32'h1);
      void'(sb_q.pop_front());
      bus_idle();
      return;
    end
    chk($sformatf("waits@%h", addr), 32'(waits), 32'(exp_waits));
    e = sb_q.pop_front();
    chk($sformatf("prdata@%h", addr), rd, e.rdata);
    chk($sformatf("pslverr@%h", addr), 32'(slv), 32'(e.slverr));
    if (wr && !err) begin
      if (d == 0) m0[idx] = data; else m2[idx] = data;
    end
    @(negedge Hclk);
    sample(d, rdy, slv, dn, rd);
    chk($sformatf("xfer_done@%h", addr), 32'(dn), 32'h1);
    chk($sformatf("pready_clr@%h", addr), 32'(rdy), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rdy, slv, dn;
    logic [31:0] rd;
    int          hi_cnt;

    for (int i = 0; i < 8; i++) begin m0[i] = '0; m2[i] = '0; end
    Hreset = 1'b1; sel0 = '0; sel2 = '0; pen = 1'b0; pwr = 1'b0; paddr = '0; pwdata = '0;
    repeat (2) @(negedge Hclk);
    for (int d = 0; d < 3; d += 2) begin
      sample(d, rdy, slv, dn, rd);
      chk($sformatf("rst_pready%0d", d), 32'(rdy), 32'h0);
      chk($sformatf("rst_pslverr%0d", d), 32'(slv), 32'h0);
      chk($sformatf("rst_done%0d", d), 32'(dn), 32'h0);
      chk($sformatf("rst_prdata%0d", d), rd, 32'h0);
    end
    Hreset = 1'b0;
    @(negedge Hclk);

    // Reset contents, back-to-back reads on the zero-wait instance.
    for (int i = 0; i < 8; i++) xfer(0, 3'b001, 1'b0, 32'(i * 4), 32'h0);
    bus_idle();

    // Write then back-to-back read.
    xfer(0, 3'b001, 1'b1, 32'h08, 32'hDEAD_BEEF);
    xfer(0, 3'b001, 1'b0, 32'h08, 32'h0);
    bus_idle();

    // Two wait states.
    xfer(2, 3'b100, 1'b1, 32'h1C, 32'h1234_5678);
    xfer(2, 3'b100, 1'b0, 32'h1C, 32'h0);
    bus_idle();

    // Error responses leave the register file untouched.
    xfer(2, 3'b100, 1'b1, 32'h20, 32'hFFFF_FFFF);
    xfer(2, 3'b100, 1'b1, 32'h02, 32'hCAFE_F00D);
    xfer(2, 3'b100, 1'b1, 32'h1000_0000, 32'h0BAD_0BAD);
    xfer(2, 3'b100, 1'b0, 32'h20, 32'h0);
    xfer(2, 3'b100, 1'b0, 32'h00, 32'h0);
    xfer(2, 3'b100, 1'b0, 32'h1C, 32'h0);
    xfer(0, 3'b001, 1'b1, 32'h03, 32'h7777_7777);
    xfer(0, 3'b001, 1'b0, 32'h00, 32'h0);
    bus_idle();

    // Foreign select bit only: no response.
    sel0 = 3'b010; pen = 1'b0; pwr = 1'b1; paddr = 32'h00; pwdata = 32'h1111_1111;
    @(negedge Hclk);
    pen = 1'b1;
    hi_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      sample(0, rdy, slv, dn, rd);
      if (rdy || dn) hi_cnt++;
      @(negedge Hclk);
    end
    chk("foreign_sel_resp", 32'(hi_cnt), 32'h0);
    bus_idle();
    xfer(0, 3'b001, 1'b0, 32'h00, 32'h0);
    xfer(0, 3'b011, 1'b1, 32'h00, 32'h1111_1111);
    xfer(0, 3'b111, 1'b0, 32'h00, 32'h0);
    bus_idle();

    // Drop select during the wait phase.
    sel2 = 3'b100; pen = 1'b0; pwr = 1'b1; paddr = 32'h04; pwdata = 32'hA5A5_A5A5;
    @(negedge Hclk);
    pen = 1'b1;
    sample(2, rdy, slv, dn, rd);
    chk("abort_wait_pready", 32'(rdy), 32'h0);
    @(negedge Hclk);
    sel2 = 3'b000; pen = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Hclk);
      sample(2, rdy, slv, dn, rd);
      if (rdy || dn) hi_cnt++;
    end
    chk("abort_wait_resp", 32'(hi_cnt), 32'h0);
    xfer(2, 3'b100, 1'b0, 32'h04, 32'h0);
    bus_idle();

    // Reset while the response is being presented.
    xfer(0, 3'b001, 1'b1, 32'h04, 32'h0000_5555);
    sel0 = 3'b001; pen = 1'b0; pwr = 1'b1; paddr = 32'h0C; pwdata = 32'h3333_3333;
    @(negedge Hclk);
    pen = 1'b1;
    sample(0, rdy, slv, dn, rd);
    chk("resp_before_rst", 32'(rdy), 32'h1);
    Hreset = 1'b1;
    @(negedge Hclk);
    sample(0, rdy, slv, dn, rd);
    chk("rst_resp_pready", 32'(rdy), 32'h0);
    chk("rst_resp_pslverr", 32'(slv), 32'h0);
    chk("rst_resp_prdata", rd, 32'h0);
    chk("rst_resp_done", 32'(dn), 32'h0);
    Hreset = 1'b0; sel0 = 3'b000; pen = 1'b0;
    for (int i = 0; i < 8; i++) begin m0[i] = '0; m2[i] = '0; end
    @(negedge Hclk);
    xfer(0, 3'b001, 1'b0, 32'h04, 32'h0);
    xfer(0, 3'b001, 1'b0, 32'h0C, 32'h0);
    xfer(0, 3'b001, 1'b0, 32'h08, 32'h0);
    bus_idle();

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
